ble_rx_scan_ctrl: RTL

Scan scheduler for the BLE receive chain. It steps the receiver through the advertising channels 37 → 38 → 39 and wraps back to 37. On each channel it requests an LO retune, waits a settle interval, then opens a listen window with the packet sniffer enabled. When a packet is detected it holds on that channel for one maximum-length packet time and reports the hit. It sits above the matched filter, timing recovery and packet sniffer, and drives the sniffer's `en` and `channel` inputs.

---
 rtl/ble_rx_pkg.sv | 21 ++
 rtl/ble_chan_seq.sv | 30 +++
 rtl/ble_rx_scan_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ble_rx_pkg.sv
// rtl/ble_rx_pkg.sv - shared types and constants for the BLE receive scan scheduler
package ble_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TUNE,
        ST_SETTLE,
        ST_LISTEN,
        ST_HOLD
    } scan_state_t;

    localparam logic [5:0] CH_ADV_FIRST = 6'd37;
    localparam logic [5:0] CH_ADV_LAST  = 6'd39;

    // Default intervals in cycles of the 16 MHz ADC clock
    localparam int DEF_SCAN_WINDOW   = 160_000;
    localparam int DEF_SETTLE_CYCLES = 1_600;
    localparam int DEF_HOLD_CYCLES   = 6_016;
    localparam int DEF_TUNE_TIMEOUT  = 4_096;

endpackage

// File: rtl/ble_chan_seq.sv
// rtl/ble_chan_seq.sv - advertising channel register, steps 37 -> 38 -> 39 -> 37
module ble_chan_seq
    import ble_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_first,
    input  logic       advance,
    output logic [5:0] channel
);

    // Anything outside the advertising range recovers to the first channel
    function automatic logic [5:0] adv_channel(input logic [5:0] ch);
        if (ch >= CH_ADV_FIRST && ch < CH_ADV_LAST)
            return ch + 6'd1;
        else
            return CH_ADV_FIRST;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            channel <= CH_ADV_FIRST;
        end else if (load_first) begin
            channel <= CH_ADV_FIRST;
        end else if (advance) begin
            channel <= adv_channel(channel);
        end
    end

endmodule

// File: rtl/ble_rx_scan_ctrl.sv
// rtl/ble_rx_scan_ctrl.sv - BLE advertising scan scheduler: tune, settle, listen, hold on detect
module ble_rx_scan_ctrl
    import ble_rx_pkg::*;
#(
    parameter int SCAN_WINDOW   = DEF_SCAN_WINDOW,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int TUNE_TIMEOUT  = DEF_TUNE_TIMEOUT,
    parameter int CNT_W         = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        packet_detected,
    input  logic        tune_ack,
    output logic        tune_req,
    output logic [5:0]  channel,
    output logic        sniffer_en,
    output logic        pkt_valid,
    output logic [5:0]  pkt_channel,
    output logic [15:0] pkt_count,
    output logic        tune_error
);

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(SCAN_WINDOW - 1);
    localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TUNE_TIMEOUT - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             pd_q;
    logic             det_edge;
    logic             tune_timeout;
    logic             win_end;
    logic             hold_end;
    logic             ch_advance;
    logic             ch_load_first;

    assign det_edge = packet_detected & ~pd_q;

    // A detect in the last listen cycle pre-empts the window expiry
    always_comb begin
        tune_timeout  = (state == ST_TUNE) && !tune_ack && (cnt == TO_LAST);
        win_end       = (state == ST_LISTEN) && !det_edge && (cnt == WIN_LAST);
        hold_end      = (state == ST_HOLD) && (cnt == HOLD_LAST);
        ch_advance    = scan_en && (tune_timeout || win_end || hold_end);
        ch_load_first = (state == ST_IDLE) && scan_en;
    end

    ble_chan_seq u_chan_seq (
        .clk        (clk),
        .rst        (rst),
        .load_first (ch_load_first),
        .advance    (ch_advance),
        .channel    (channel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pd_q        <= 1'b0;
            tune_req    <= 1'b0;
            sniffer_en  <= 1'b0;
            pkt_valid   <= 1'b0;
            tune_error  <= 1'b0;
            pkt_channel <= '0;
            pkt_count   <= '0;
        end else begin
            pd_q       <= packet_detected;
            pkt_valid  <= 1'b0;
            tune_error <= 1'b0;
            if (state != ST_IDLE && !scan_en) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                tune_req   <= 1'b0;
                sniffer_en <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (scan_en) begin
                            state    <= ST_TUNE;
                            cnt      <= '0;
                            tune_req <= 1'b1;
                        end
                    end
                    ST_TUNE: begin
                        if (tune_ack) begin
                            state    <= ST_SETTLE;
                            cnt      <= '0;
                            tune_req <= 1'b0;
                        end else if (tune_timeout) begin
                            tune_error <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == SET_LAST) begin
                            state      <= ST_LISTEN;
                            cnt        <= '0;
                            sniffer_en <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_LISTEN: begin
                        if (det_edge) begin
                            state       <= ST_HOLD;
                            cnt         <= '0;
                            pkt_valid   <= 1'b1;
                            pkt_channel <= channel;
                            if (pkt_count != 16'hFFFF)
                                pkt_count <= pkt_count + 16'd1;
                        end else if (win_end) begin
                            state      <= ST_TUNE;
                            cnt        <= '0;
                            sniffer_en <= 1'b0;
                            tune_req   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (hold_end) begin
                            state      <= ST_TUNE;
                            cnt        <= '0;
                            sniffer_en <= 1'b0;
                            tune_req   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        tune_req   <= 1'b0;
                        sniffer_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
